// File: rtl/ip_ram.sv
// -----------------------------------------------------------------------------
// ip_ram : self-checking on-chip RAM exerciser
//
// Internal single-port synchronous RAM plus a controller that writes a known
// pattern (addr + seed) to every word, reads every word back and compares it.
// Runs autonomously after reset; the status outputs are optional to connect.
//
// Parameters
//   DW      data width of a RAM word
//   DEPTH   number of RAM words (address width = $clog2(DEPTH))
//
// Ports
//   sys_clk    system clock, all logic on the rising edge
//   sys_rst_n  asynchronous active-low reset (synchronous release expected)
//   rd_data    registered RAM read data
//   rd_valid   one-cycle pulse: rd_data holds a readback word
//   done       pass complete
//   error      sticky: a readback mismatch was seen
//   err_cnt    mismatch count, saturating at 255
//
// Configuration macro
//   RAM_LOOP_EN  defined  : DONE lasts one cycle, seed increments, a new pass
//                           starts; error/err_cnt keep accumulating.
//                undefined: single pass with seed 0, parks in DONE.
// -----------------------------------------------------------------------------
module ip_ram #(
   parameter int DW    = 8,
   parameter int DEPTH = 16
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          done,
   output logic          error,
   output logic [7:0]    err_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_CHECK,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [AW-1:0] addr;
   logic [DW-1:0] seed;
   logic [DW-1:0] pattern;
   logic [DW-1:0] exp_q;
   logic          last;
   logic          en;
   logic          we;

   logic [DW-1:0] mem [DEPTH];

   assign last    = (addr == LAST_ADDR);
   // Pattern word for the current address; used both as write data and as
   // the expected value that travels one stage alongside the read.
   assign pattern = DW'(addr) + seed;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_WRITE;
         S_WRITE: if (last) state_nxt = S_READ;
         S_READ:  if (last) state_nxt = S_CHECK;
         S_CHECK: state_nxt = S_DONE;
`ifdef RAM_LOOP_EN
         S_DONE:  state_nxt = S_WRITE;
`else
         S_DONE:  state_nxt = S_DONE;
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      en   = 1'b0;
      we   = 1'b0;
      done = 1'b0;
      case (state)
         S_WRITE: begin
            en = 1'b1;
            we = 1'b1;
         end
         S_READ:  en   = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         addr     <= '0;
         seed     <= '0;
         exp_q    <= '0;
         rd_valid <= 1'b0;
         error    <= 1'b0;
         err_cnt  <= '0;
      end else begin
         if (en) begin
            addr <= last ? '0 : addr + 1'b1;
         end else begin
            addr <= '0;
         end

`ifdef RAM_LOOP_EN
         if (state == S_DONE) begin
            seed <= seed + 1'b1;
         end
`endif

         rd_valid <= (state == S_READ);
         if (state == S_READ) begin
            exp_q <= pattern;
         end

         // Compare one cycle after the read was issued, when rd_data and
         // exp_q both describe the same address.
         if (rd_valid && (rd_data != exp_q)) begin
            error <= 1'b1;
            if (err_cnt != '1) begin
               err_cnt <= err_cnt + 1'b1;
            end
         end
      end
   end

   // --------------------------------------------------------------- RAM
   always_ff @(posedge sys_clk) begin
      if (en && we) begin
         mem[addr] <= pattern;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_data <= '0;
      end else if (en && !we) begin
         rd_data <= mem[addr];
      end
   end

endmodule

// File: tb/tb_ip_ram.sv
// -----------------------------------------------------------------------------
// tb_ip_ram : self-checking bench for ip_ram.
//
// A pass-level model (write phase, read phase, compare one cycle later) plus a
// memory image predicts every output each cycle. Random resets and random
// hierarchical corruption of RAM words are applied to both DUT and model.
// -----------------------------------------------------------------------------
module tb_ip_ram;

   localparam int DW = 8;
   localparam int D  = 16;
   localparam int P  = 2 * D + 2;   // edges per pass once running

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          done;
   logic          error;
   logic [7:0]    err_cnt;

   ip_ram #(.DW(DW), .DEPTH(D)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .done      (done),
      .error     (error),
      .err_cnt   (err_cnt)
   );

   always #10 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   // model state
   int            t;                  // rising edges since reset release
   logic [DW-1:0] mem_m [D];
   logic [DW-1:0] m_rd;
   logic          m_valid;
   logic          m_done;
   logic          m_error;
   logic [7:0]    m_err;
   bit            pend;
   logic [DW-1:0] pend_val;
   logic [DW-1:0] pend_exp;

   // observation
   int            first_done;
   int            done_pulses;
   logic [DW-1:0] cap [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0d)", nm, act, exp, t);
      end
   endtask

   task automatic model_reset();
      t           = 0;
      m_rd        = '0;
      m_valid     = 1'b0;
      m_done      = 1'b0;
      m_error     = 1'b0;
      m_err       = '0;
      pend        = 1'b0;
      first_done  = -1;
      done_pulses = 0;
      cap.delete();
   endtask

   // Advance the model by the rising edge numbered t.
   task automatic model_edge();
      int w, p, r, i;
      logic [DW-1:0] seed;
      w = t - 1;
`ifndef RAM_LOOP_EN
      if (w >= P) begin
         m_valid = 1'b0;
         m_done  = 1'b1;
         return;
      end
`endif
      p    = w / P;
      r    = w % P;
      seed = DW'(p);
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (pend) begin
         if (pend_val != pend_exp) begin
            m_error = 1'b1;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
         end
         pend = 1'b0;
      end
      if (r >= 1 && r <= D) begin
         mem_m[r-1] = DW'(r - 1) + seed;
      end else if (r >= D + 1 && r <= 2 * D) begin
         i        = r - D - 1;
         m_rd     = mem_m[i];
         m_valid  = 1'b1;
         pend     = 1'b1;
         pend_val = mem_m[i];
         pend_exp = DW'(i) + seed;
      end else if (r == 2 * D + 1) begin
         m_done = 1'b1;
      end
   endtask

   task automatic compare_outputs();
      chk("rd_valid", 32'(rd_valid), 32'(m_valid));
      chk("done",     32'(done),     32'(m_done));
      chk("error",    32'(error),    32'(m_error));
      chk("err_cnt",  32'(err_cnt),  32'(m_err));
      chk("rd_data",  32'(rd_data),  32'(m_rd));
   endtask

   task automatic cycle();
      @(negedge sys_clk);
      if (sys_rst_n) begin
         t++;
         model_edge();
      end
      compare_outputs();
      if (rd_valid === 1'b1) cap.push_back(rd_data);
      if (done === 1'b1) begin
         done_pulses++;
         if (first_done < 0) first_done = t;
      end
   endtask

   task automatic do_reset(input int n);
      sys_rst_n = 1'b0;
      model_reset();
      #1;
      compare_outputs();   // asynchronous clear must be visible at once
      repeat (n) cycle();
      sys_rst_n = 1'b1;
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (t < target && guard < 2000) begin
         cycle();
         guard++;
      end
      chk("run_to_budget", 32'(t), 32'(target));
   endtask

   task automatic inject(input int j, input logic [DW-1:0] v);
      dut.mem[j] = v;
      mem_m[j]   = v;
   endtask

   initial begin
      int len;
      logic [DW-1:0] v;

      sys_rst_n = 1'b0;
      model_reset();
      repeat (3) cycle();
      sys_rst_n = 1'b1;

      // clean pass(es)
`ifdef RAM_LOOP_EN
      run_to(70);
      chk("first_done_t", 32'(first_done), 32'd34);
      chk("done_pulses", 32'(done_pulses), 32'd2);
      chk("readback_count", 32'(cap.size()), 32'd32);
      for (int i = 0; i < 16; i++) begin
         v = (i + 16 < cap.size()) ? cap[i+16] : 'x;
         chk("pass1_data", 32'(v), 32'(i + 1));
      end
`else
      run_to(40);
      chk("first_done_t", 32'(first_done), 32'd34);
      chk("readback_count", 32'(cap.size()), 32'd16);
      chk("done_held", 32'(done), 32'd1);
`endif
      for (int i = 0; i < 16; i++) begin
         v = (i < cap.size()) ? cap[i] : 'x;
         chk("pass0_data", 32'(v), 32'(i));
      end
      chk("clean_error", 32'(error), 32'd0);
      chk("clean_err_cnt", 32'(err_cnt), 32'd0);

      // corrupt word 5 after its write, before its read
      do_reset(2);
      run_to(D + 1);
      inject(5, 8'hAA);
      run_to(34);
      chk("inj_done", 32'(done), 32'd1);
      chk("inj_error", 32'(error), 32'd1);
      chk("inj_err_cnt", 32'(err_cnt), 32'd1);
      v = (cap.size() > 5) ? cap[5] : 'x;
      chk("inj_readback", 32'(v), 32'hAA);

      // reset in the middle of the write phase
      do_reset(1);
      run_to(10);
      do_reset(2);
      run_to(40);
      chk("restart_done_t", 32'(first_done), 32'd34);
      chk("restart_error", 32'(error), 32'd0);

      // random resets and random RAM corruption
      repeat (15) begin
         do_reset(int'($urandom_range(1, 3)));
         len = int'($urandom_range(5, 110));
         repeat (len) begin
            cycle();
            if ($urandom_range(0, 7) == 0)
               inject(int'($urandom_range(0, D - 1)), DW'($urandom));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
